// File: rtl/ppm_symbol_decoder_pkg.sv
// Shared types and defaults for the L-PPM symbol decoder.
// Build option PPM_ERRCNT_EN enables the saturating error counter in the top.
package ppm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_BITS_PER_SYM = 2;
   localparam int DEF_SPS_LOG2     = 1;
   localparam int ERRCNT_W         = 16;

endpackage

// File: rtl/ppm_symbol_decoder_if.sv
// Line-side and result-side signals of the PPM decoder.
// slave = decoder, master = whatever drives en/din and consumes the results.
interface ppm_symbol_decoder_if
   import ppm_pkg::*;
   #(parameter int BITS_PER_SYM = DEF_BITS_PER_SYM)
   ();

   logic                    en;
   logic                    din;
   logic [BITS_PER_SYM-1:0] data_out;
   logic                    data_valid;
   logic                    sym_err;
   logic                    busy;

   modport master (
      output en, din,
      input  data_out, data_valid, sym_err, busy
   );

   modport slave (
      input  en, din,
      output data_out, data_valid, sym_err, busy
   );

endinterface

// File: rtl/ppm_symbol_decoder_frame_counter.sv
// Sample counter across one PPM frame; held at 0 while en is low, wraps at FRAME-1.
module ppm_frame_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk16,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             frame_last
);

   always_ff @(posedge clk16) begin
      if (rst || !en) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // FRAME is a power of two, so its last sample is the all-ones count
   assign frame_last = en && (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/ppm_symbol_decoder.sv
// L-PPM demodulator: finds the single falling edge per frame and reports its slot.
// Build option PPM_ERRCNT_EN adds a saturating count of errored frames on err_count.
//
// state | meaning
// IDLE  | waiting for en; a cycle with en=1 here is already sample 0 of a frame
// RUN   | framing and decoding, frame counter running
module ppm_symbol_decoder
   import ppm_pkg::*;
#(
   parameter int BITS_PER_SYM = DEF_BITS_PER_SYM,
   parameter int SPS_LOG2     = DEF_SPS_LOG2
) (
   input  logic                clk16,
   input  logic                rst,
   ppm_symbol_decoder_if.slave bus
`ifdef PPM_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0] err_count
`endif
);

   localparam int CNT_W = BITS_PER_SYM + SPS_LOG2;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic                    frame_last;
   logic                    din_q;
   logic                    pulse;
   logic [1:0]              edge_cnt;
   logic [1:0]              edge_tot;
   logic [BITS_PER_SYM-1:0] slot;
   logic [BITS_PER_SYM-1:0] slot_fin;
   logic [BITS_PER_SYM-1:0] data_out_q;
   logic                    data_valid_q;
   logic                    sym_err_q;

   ppm_frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
      .clk16      (clk16),
      .rst        (rst),
      .en         (bus.en),
      .cnt        (cnt),
      .frame_last (frame_last)
   );

   always_ff @(posedge clk16) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.en)  state_nxt = RUN;
         RUN:     if (!bus.en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Fold in the current sample so an edge on sample FRAME-1 still counts for its frame
   always_comb begin
      pulse    = bus.en && din_q && !bus.din;
      edge_tot = edge_cnt;
      slot_fin = slot;
      if (pulse) begin
         edge_tot = (edge_cnt == 2'd0) ? 2'd1 : 2'd2;
         if (edge_cnt == 2'd0) begin
            slot_fin = cnt[CNT_W-1:SPS_LOG2];
         end
      end
   end

   always_ff @(posedge clk16) begin
      if (rst) begin
         din_q        <= 1'b1;
         edge_cnt     <= 2'd0;
         slot         <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         sym_err_q    <= 1'b0;
      end else begin
         data_valid_q <= frame_last;
         sym_err_q    <= frame_last && (edge_tot != 2'd1);
         if (frame_last) begin
            data_out_q <= (edge_tot == 2'd1) ? slot_fin : '0;
         end
         // din_q only resets when not running, so a low held over a boundary is not an edge
         din_q <= bus.en ? bus.din : 1'b1;
         if (!bus.en || frame_last) begin
            edge_cnt <= 2'd0;
            slot     <= '0;
         end else begin
            edge_cnt <= edge_tot;
            slot     <= slot_fin;
         end
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.sym_err    = sym_err_q;
   assign bus.busy       = (state == RUN);

`ifdef PPM_ERRCNT_EN
   always_ff @(posedge clk16) begin
      if (rst) begin
         err_count <= '0;
      end else if (sym_err_q && (err_count != {ERRCNT_W{1'b1}})) begin
         err_count <= err_count + ERRCNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ppm_symbol_decoder.sv
// Self-checking bench for ppm_symbol_decoder at default parameters (L=4, SPS=2, FRAME=8).
// Define PPM_ERRCNT_EN to also exercise err_count.
module tb_ppm_symbol_decoder;
   import ppm_pkg::*;

   localparam int FRAME = 8;
   localparam int SPS   = 2;

   logic clk16 = 1'b0;
   logic rst;
`ifdef PPM_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_count;
   int exp_err;
`endif

   int checks = 0;
   int errors = 0;
   logic model_prev;

   ppm_symbol_decoder_if bus ();

   ppm_symbol_decoder dut (
      .clk16     (clk16),
      .rst       (rst),
      .bus       (bus)
`ifdef PPM_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk16 = ~clk16;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic e, input logic d);
      bus.en  = e;
      bus.din = d;
      @(posedge clk16);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b1);
      model_prev = 1'b1;
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_valid", 32'(bus.data_valid), 32'd0);
   endtask

   // s[i] is the din level on sample i of the frame
   task automatic frame(input string tag, input logic [FRAME-1:0] s);
      int   edges;
      int   slot;
      logic prev;
      edges = 0;
      slot  = 0;
      prev  = model_prev;
      for (int i = 0; i < FRAME; i++) begin
         if (prev && !s[i]) begin
            if (edges == 0) slot = i / SPS;
            edges++;
         end
         prev = s[i];
      end
      model_prev = prev;
      for (int i = 0; i < FRAME; i++) begin
         step(1'b1, s[i]);
         chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
         chk({tag, "_valid"}, 32'(bus.data_valid), (i == FRAME - 1) ? 32'd1 : 32'd0);
      end
      chk({tag, "_err"}, 32'(bus.sym_err), (edges != 1) ? 32'd1 : 32'd0);
      chk({tag, "_data"}, 32'(bus.data_out), (edges == 1) ? 32'(slot) : 32'd0);
`ifdef PPM_ERRCNT_EN
      if (edges != 1) exp_err++;
`endif
   endtask

   task automatic partial(input string tag, input logic [FRAME-1:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, s[i]);
         chk({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
      end
      step(1'b0, 1'b1);
      model_prev = 1'b1;
      chk({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_abort_valid"}, 32'(bus.data_valid), 32'd0);
      step(1'b0, 1'b1);
      chk({tag, "_abort_valid2"}, 32'(bus.data_valid), 32'd0);
   endtask

   task automatic do_reset(input logic e);
      rst = 1'b1;
      step(e, 1'b1);
      rst = 1'b0;
      model_prev = 1'b1;
`ifdef PPM_ERRCNT_EN
      exp_err = 0;
`endif
   endtask

   initial begin
      logic [FRAME-1:0] s;
      int               kind;
      int               p;
      rst     = 1'b1;
      bus.en  = 1'b0;
      bus.din = 1'b1;
      model_prev = 1'b1;
`ifdef PPM_ERRCNT_EN
      exp_err = 0;
`endif
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      rst = 1'b0;
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_err", 32'(bus.sym_err), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef PPM_ERRCNT_EN
      chk("rst_errcnt", 32'(err_count), 32'd0);
`endif

      // first frame: low on samples 0-1 right at en rise
      frame("t1", ~8'b0000_0011);
      chk("t1_data_fixed", 32'(bus.data_out), 32'd0);
      chk("t1_err_fixed", 32'(bus.sym_err), 32'd0);

      // four back-to-back frames, pulses in slots 0..3
      for (int k = 0; k < 4; k++) begin
         s = ~(8'b0000_0011 << (2 * k));
         frame("t2", s);
         chk("t2_data_fixed", 32'(bus.data_out), 32'(k));
      end
      idle();

      frame("t3_none", 8'hFF);
      chk("t3_none_err_fixed", 32'(bus.sym_err), 32'd1);
      frame("t3_two", ~8'b0010_0010);
      chk("t3_two_err_fixed", 32'(bus.sym_err), 32'd1);
      idle();

      partial("t4", ~8'b0000_1100, 4);
      frame("t4_after", ~8'b0011_0000);
      chk("t4_after_fixed", 32'(bus.data_out), 32'd2);

      // low held across the boundary: 3 then an error frame
      frame("t5a", ~8'b1000_0000);
      chk("t5a_fixed", 32'(bus.data_out), 32'd3);
      frame("t5b", ~8'b0000_0011);
      chk("t5b_fixed", 32'(bus.sym_err), 32'd1);
      frame("t5c", ~8'b1100_0000);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      do_reset(1'b1);
      chk("t5_rst_data", 32'(bus.data_out), 32'd0);
      chk("t5_rst_valid", 32'(bus.data_valid), 32'd0);
      chk("t5_rst_err", 32'(bus.sym_err), 32'd0);
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      idle();

      // randomized frames, occasional aborts
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 4));
         p    = int'($urandom_range(0, FRAME - 1));
         case (kind)
            0:       s = ~(8'b0000_0011 << (2 * (p / 2)));
            1:       s = 8'($urandom);
            2:       s = 8'hFF;
            3:       s = ~(8'b0000_0001 << p);
            default: s = 8'($urandom) | 8'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) begin
            partial("rnd_part", s, int'($urandom_range(1, FRAME - 1)));
         end else begin
            frame("rnd", s);
         end
         if ($urandom_range(0, 7) == 0) idle();
      end
      idle();

`ifdef PPM_ERRCNT_EN
      chk("rnd_errcnt", 32'(err_count), 32'(exp_err));
      do_reset(1'b0);
      frame("t6a", 8'hFF);
      frame("t6b", ~8'b0010_0010);
      frame("t6c", 8'hFF);
      idle();
      chk("t6_errcnt", 32'(err_count), 32'd3);
      step(1'b1, 1'b1);
      idle();
      idle();
      chk("t6_errcnt_toggle", 32'(err_count), 32'd3);
      do_reset(1'b0);
      chk("t6_errcnt_rst", 32'(err_count), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
